mem_access_controller: RTL and testbench
========================================

Name: mem_access_controller

Overview:
Sequences 32-bit data-memory accesses from the MEM stage onto an external 16-bit asynchronous SRAM. Each access is split into two 16-bit half-word phases, and each phase has programmable wait states. The block drops ready while busy; ~ready is the pipeline freeze signal. It sits between MEM-stage control (read enable, write enable, ALU result as address, Rm value as write data) and the SRAM pins.

Parameters:
BASE_ADDR, 1024, byte address mapped to SRAM word 0
WAIT_CYCLES, 2, extra cycles per half-word phase (phase length = WAIT_CYCLES+1); legal range 1..15
SRAM_AW, 18, SRAM address width (half-word granularity)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
MEM_R_EN  in  1  read request, held stable until ready
MEM_W_EN  in  1  write request, held stable until ready
address  in  32  byte address (ALU result)
write_data  in  32  store data (Rm value)
read_data  out  32  load result, valid when ready rises after a read
ready  out  1  high = no access in progress; ~ready freezes pipeline
sram_addr  out  SRAM_AW  SRAM half-word address
sram_dq_out  out  16  SRAM write data
sram_dq_in  in  16  SRAM read data
sram_dq_oe  out  1  drive enable for the external tristate
sram_we_n  out  1  SRAM write strobe, active-low
mem_err  out  1  out-of-range flag (MEM_ERR_EN only; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, read_data=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, mem_err=0, wait counter=0.
- Address map: offs = address - BASE_ADDR. Word = offs[SRAM_AW:2]. Low half at sram_addr = {word,0}; high half at {word,1}. address[1:0] is ignored.
- State machine: IDLE -> LOW -> HIGH -> DONE -> IDLE.
- IDLE: leave when MEM_R_EN|MEM_W_EN is sampled high; latch the op and address. Write wins if both are high (illegal combination).
- LOW and HIGH:
  - Each phase lasts WAIT_CYCLES+1 cycles, counted by a 4-bit counter.
  - sram_addr is held for the whole phase.
  - Write phase: sram_dq_oe=1 for the whole phase. sram_dq_out = write_data[15:0] in LOW, write_data[31:16] in HIGH. sram_we_n=0 on counts 0..WAIT_CYCLES-1 and 1 on the last count, which provides address/data hold.
  - Read phase: sram_dq_oe=0, sram_we_n=1. sram_dq_in is sampled on the last count into read_data[15:0] (LOW) or read_data[31:16] (HIGH).
- DONE: one cycle; then unconditionally return to IDLE.
- ready (combinational) = (state==IDLE && !(MEM_R_EN|MEM_W_EN)) || state==DONE.
- Latency: ready is low for 1+2*(WAIT_CYCLES+1) cycles and high in DONE. Default: 7 low cycles, high on the 8th.
- Back-to-back: a request present in the IDLE cycle after DONE belongs to the next instruction and starts a new access; no idle bubble is inserted.
- read_data holds its last value until the next read overwrites it; writes do not disturb it.
- Reset mid-operation: abort immediately to IDLE with reset values. A partially written SRAM word is not rolled back.

Optional Feature:
MEM_ERR_EN
- Defined: if address < BASE_ADDR or offs >= 2^(SRAM_AW+1), the request goes IDLE->DONE with no SRAM strobes. mem_err=1 for the DONE cycle; a read returns read_data=0.
- Undefined: no range check; the address wraps modulo SRAM size; mem_err is tied to 0.

Decomposition:
- Shared package: state enum (IDLE, LOW, HIGH, DONE), BASE_ADDR default, half-word width constant 16.
- Sub-module: one natural sub-module, wait_counter (load/decrement/terminal-count), reused per phase. Address translation stays inline.

Test Plan:
- Write 0x12345678 to address 1024 -> SRAM word 0 = 0x5678 and word 1 = 0x1234; sram_we_n low 2 cycles per phase; ready low exactly 7 cycles.
- Read address 1024 after the above, SRAM model returning stored halves -> read_data=0x12345678 when ready rises; sram_dq_oe=0 throughout.
- Write 0xDEADBEEF to 1032 followed immediately by a read of 1032 -> second access starts the cycle after DONE; read_data=0xDEADBEEF; sram_addr 4/5 used.
- Assert rst during HIGH phase of a write -> next cycle state=IDLE, sram_we_n=1, sram_dq_oe=0, ready=1 with no request.
- MEM_R_EN and MEM_W_EN both high, address 1028, data 0xA5A5 -> performed as write to SRAM words 2/3.
- MEM_ERR_EN defined, read of address 0x10 -> no strobes, mem_err=1 in DONE, read_data=0, ready low 1 cycle.

Source files
------------

// File: rtl/mem_access_controller_pkg.sv
// Shared types and constants for the 32-bit-over-16-bit SRAM access controller.
package mem_access_controller_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh,
    StDone
  } state_e;

  localparam int unsigned BaseAddrDefault = 1024;
  localparam int unsigned HalfW           = 16;

endpackage

// File: rtl/mem_access_controller_wait_counter.sv
// Per-phase wait-state counter: load, decrement to zero, flag terminal count.
module mem_access_controller_wait_counter
  import mem_access_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       dec,
  output logic       terminal
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == 4'd0);

endmodule

// File: rtl/mem_access_controller.sv
// Splits 32-bit MEM-stage accesses into two wait-stated 16-bit SRAM phases.
// Define MEM_ERR_EN to enable the out-of-range check and the mem_err flag.
module mem_access_controller
  import mem_access_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = BaseAddrDefault,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [HalfW-1:0]   sram_dq_out,
  input  logic [HalfW-1:0]   sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               mem_err
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  state_e             state_q, state_d;
  logic               op_write_q, op_write_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        read_data_q, read_data_d;
  logic               cnt_load, cnt_dec, cnt_tc;
  logic               req, in_phase, range_err;
  logic [31:0]        offs;

  assign req  = MEM_R_EN | MEM_W_EN;
  assign offs = address - 32'(BASE_ADDR);

  // Byte-lane bits and the bits above the SRAM window carry no address information.
  logic unused_offs;
  assign unused_offs = ^{offs[31:SRAM_AW+1], offs[1:0]};

`ifdef MEM_ERR_EN
  logic err_q, err_d;
  assign range_err = (address < 32'(BASE_ADDR)) || ((offs >> (SRAM_AW + 1)) != 32'd0);
`else
  assign range_err = 1'b0;
`endif

  mem_access_controller_wait_counter u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (WaitLoad),
    .dec        (cnt_dec),
    .terminal   (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    op_write_d  = op_write_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          // Write wins when both enables are high.
          op_write_d = MEM_W_EN;
          word_d     = offs[SRAM_AW:2];
          wdata_d    = write_data;
          if (range_err) begin
            state_d = StDone;
            if (!MEM_W_EN) read_data_d = '0;
          end else begin
            state_d  = StLow;
            cnt_load = 1'b1;
          end
        end
      end
      StLow: begin
        cnt_dec = 1'b1;
        if (cnt_tc) begin
          if (!op_write_q) read_data_d[15:0] = sram_dq_in;
          state_d  = StHigh;
          cnt_load = 1'b1;
        end
      end
      StHigh: begin
        cnt_dec = 1'b1;
        if (cnt_tc) begin
          if (!op_write_q) read_data_d[31:16] = sram_dq_in;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_write_q  <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      op_write_q  <= op_write_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
    end
  end

`ifdef MEM_ERR_EN
  always_comb begin
    err_d = err_q;
    if (state_q == StIdle && req) err_d = range_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign mem_err = (state_q == StDone) && err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign in_phase    = (state_q == StLow) || (state_q == StHigh);
  assign sram_addr   = {word_q, (state_q == StHigh)};
  assign sram_dq_oe  = in_phase && op_write_q;
  // Strobe released on the terminal count to give address/data hold.
  assign sram_we_n   = !(sram_dq_oe && !cnt_tc);
  assign sram_dq_out = !sram_dq_oe          ? '0 :
                       (state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0];
  assign ready       = ((state_q == StIdle) && !req) || (state_q == StDone);
  assign read_data   = read_data_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller with an SRAM model and a word-level reference.
module tb_mem_access_controller;

  localparam int W      = 2;
  localparam int AW     = 18;
  localparam int BASE   = 1024;
  localparam int LAT    = 1 + 2 * (W + 1);
  localparam int WE_LOW = 2 * W;
  localparam int OE_CYC = 2 * (W + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          MEM_R_EN = 1'b0;
  logic          MEM_W_EN = 1'b0;
  logic [31:0]   address = '0;
  logic [31:0]   write_data = '0;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic [15:0]   sram_dq_in;
  logic          sram_dq_oe;
  logic          sram_we_n;
  logic          mem_err;

  int total = 0;
  int bad   = 0;

  mem_access_controller #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (W),
    .SRAM_AW     (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .mem_err     (mem_err)
  );

  always #5 clk = ~clk;

  // External SRAM: half-word array, write while strobe low, asynchronous read.
  logic [15:0] sram_mem [0:1023];
  assign sram_dq_in = sram_mem[sram_addr[9:0]];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr[9:0]] <= sram_dq_out;
  end

  // Word-level reference: what each 32-bit word should hold.
  logic [31:0] ref_mem [0:127];
  bit          written [0:127];
  logic [31:0] last_read;

  int          nlow, nwe, noe, nbus;
  logic [31:0] rd;
  logic        err;

  task automatic run_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input bit b2b,
                            output int o_low, output int o_we, output int o_oe,
                            output int o_bus, output logic [31:0] o_rd, output logic o_err);
    logic [31:0]   offs;
    logic [AW-1:0] exp_addr;
    int            k, half;
    offs = a - 32'(BASE);
    MEM_R_EN = r; MEM_W_EN = w; address = a; write_data = d;
    o_low = 0; o_we = 0; o_oe = 0; o_bus = 0; k = 0;
    if (b2b) @(negedge clk);
    #1;
    for (int i = 0; i < 64; i++) begin
      if (ready) break;
      k++; o_low++;
      if (!sram_we_n) o_we++;
      if (sram_dq_oe) o_oe++;
      if (k >= 2) begin
        half     = (k - 2) / (W + 1);
        exp_addr = AW'({offs[AW:2], 1'b0}) + AW'(half);
        if (sram_addr !== exp_addr) o_bus++;
        if (w && !sram_we_n && sram_dq_out !== (half == 1 ? d[31:16] : d[15:0])) o_bus++;
      end
      @(negedge clk); #1;
    end
    o_rd = read_data; o_err = mem_err;
    MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if ({ready, sram_we_n, sram_dq_oe, mem_err} !== 4'b1100) begin bad++;
      $display("FAIL reset_ctl got=%b want=1100", {ready, sram_we_n, sram_dq_oe, mem_err}); end
    total++; if (read_data !== 32'h0) begin bad++;
      $display("FAIL reset_rdata got=%h want=0", read_data); end
    total++; if ({sram_addr, sram_dq_out} !== '0) begin bad++;
      $display("FAIL reset_bus got=%h/%h want=0/0", sram_addr, sram_dq_out); end
    rst = 1'b0;
    last_read = 32'h0;
  endtask

  task automatic test_write_basic();
    run_access(1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b0, nlow, nwe, noe, nbus, rd, err);
    ref_mem[0] = 32'h12345678; written[0] = 1'b1;
    total++; if (nlow !== LAT) begin bad++; $display("FAIL wr_latency got=%0d want=%0d", nlow, LAT); end
    total++; if (nwe !== WE_LOW) begin bad++; $display("FAIL wr_we_low got=%0d want=%0d", nwe, WE_LOW); end
    total++; if (noe !== OE_CYC) begin bad++; $display("FAIL wr_oe got=%0d want=%0d", noe, OE_CYC); end
    total++; if (nbus !== 0) begin bad++; $display("FAIL wr_bus got=%0d want=0", nbus); end
    total++; if ({sram_mem[1], sram_mem[0]} !== 32'h12345678) begin bad++;
      $display("FAIL wr_sram got=%h%h want=12345678", sram_mem[1], sram_mem[0]); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", err); end
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, nlow, nwe, noe, nbus, rd, err);
    last_read = ref_mem[0];
    total++; if (rd !== ref_mem[0]) begin bad++; $display("FAIL rd_data got=%h want=%h", rd, ref_mem[0]); end
    total++; if ({nwe, noe} !== {32'd0, 32'd0}) begin bad++;
      $display("FAIL rd_strobes got=%0d/%0d want=0/0", nwe, noe); end
    total++; if (nlow !== LAT) begin bad++; $display("FAIL rd_latency got=%0d want=%0d", nlow, LAT); end
    total++; if (nbus !== 0) begin bad++; $display("FAIL rd_bus got=%0d want=0", nbus); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0, nlow, nwe, noe, nbus, rd, err);
    ref_mem[2] = 32'hDEADBEEF; written[2] = 1'b1;
    total++; if (nbus !== 0) begin bad++; $display("FAIL b2b_wr_bus got=%0d want=0", nbus); end
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, nlow, nwe, noe, nbus, rd, err);
    last_read = ref_mem[2];
    total++; if (nlow !== LAT) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", nlow, LAT); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_data got=%h want=deadbeef", rd); end
    total++; if (nbus !== 0) begin bad++; $display("FAIL b2b_rd_bus got=%0d want=0", nbus); end
    @(negedge clk);
  endtask

  task automatic test_both_high();
    run_access(1'b1, 1'b1, 32'd1028, 32'h0000A5A5, 1'b0, nlow, nwe, noe, nbus, rd, err);
    ref_mem[1] = 32'h0000A5A5; written[1] = 1'b1;
    total++; if (nwe !== WE_LOW) begin bad++; $display("FAIL both_we got=%0d want=%0d", nwe, WE_LOW); end
    total++; if ({sram_mem[3], sram_mem[2]} !== 32'h0000A5A5) begin bad++;
      $display("FAIL both_sram got=%h%h want=0000a5a5", sram_mem[3], sram_mem[2]); end
    total++; if (rd !== last_read) begin bad++; $display("FAIL both_rd_hold got=%h want=%h", rd, last_read); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    // Word 300 lies outside the random window, so it never enters the reference.
    MEM_W_EN = 1'b1; address = 32'(BASE + 1200); write_data = 32'hCAFEF00D;
    repeat (W + 2) @(negedge clk);
    #1;
    total++; if ({sram_we_n, sram_addr} !== {1'b0, AW'(601)}) begin bad++;
      $display("FAIL mid_phase got=%b/%0d want=0/601", sram_we_n, sram_addr); end
    rst = 1'b1; MEM_W_EN = 1'b0;
    @(negedge clk); #1;
    total++; if ({ready, sram_we_n, sram_dq_oe} !== 3'b110) begin bad++;
      $display("FAIL mid_abort got=%b want=110", {ready, sram_we_n, sram_dq_oe}); end
    total++; if (sram_mem[600] !== 16'hF00D) begin bad++;
      $display("FAIL mid_low_half got=%h want=f00d", sram_mem[600]); end
    rst = 1'b0;
    last_read = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic        w;
    logic [31:0] d, a;
    int          word;
    bit          b2b;
    for (int it = 0; it < 40; it++) begin
      word = $urandom_range(127, 0);
      w    = 1'($urandom_range(1, 0));
      if (!written[word]) w = 1'b1;
      d    = $urandom;
      a    = 32'(BASE + word * 4) + 32'($urandom_range(3, 0));
      b2b  = (it > 0) && ($urandom_range(1, 0) == 1);
      if (!b2b) @(negedge clk);
      run_access(!w, w, a, d, b2b, nlow, nwe, noe, nbus, rd, err);
      if (w) begin
        ref_mem[word] = d; written[word] = 1'b1;
      end else begin
        last_read = ref_mem[word];
      end
      total++; if (nlow !== LAT) begin bad++; $display("FAIL rnd_latency it=%0d got=%0d want=%0d", it, nlow, LAT); end
      total++; if (nwe !== (w ? WE_LOW : 0)) begin bad++; $display("FAIL rnd_we it=%0d got=%0d", it, nwe); end
      total++; if (nbus !== 0) begin bad++; $display("FAIL rnd_bus it=%0d got=%0d want=0", it, nbus); end
      total++; if (rd !== last_read) begin bad++;
        $display("FAIL rnd_rdata it=%0d got=%h want=%h", it, rd, last_read); end
    end
    @(negedge clk);
  endtask

  task automatic test_mem_err();
`ifdef MEM_ERR_EN
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, nlow, nwe, noe, nbus, rd, err);
    last_read = 32'h0;
    total++; if (nlow !== 1) begin bad++; $display("FAIL err_latency got=%0d want=1", nlow); end
    total++; if ({nwe, noe} !== {32'd0, 32'd0}) begin bad++;
      $display("FAIL err_strobes got=%0d/%0d want=0/0", nwe, noe); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_flag got=%b want=1", err); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL err_rdata got=%h want=0", rd); end
    @(negedge clk);
    run_access(1'b0, 1'b1, 32'(BASE) + (32'd1 << (AW + 1)), 32'h1, 1'b0,
               nlow, nwe, noe, nbus, rd, err);
    total++; if ({err, nwe} !== {1'b1, 32'd0}) begin bad++;
      $display("FAIL err_high got=%b/%0d want=1/0", err, nwe); end
`else
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, nlow, nwe, noe, nbus, rd, err);
    last_read = ref_mem[0];
    total++; if ({err, mem_err} !== 2'b00) begin bad++;
      $display("FAIL err_tied got=%b want=00", {err, mem_err}); end
    total++; if (rd !== ref_mem[0]) begin bad++; $display("FAIL err_off_rd got=%h want=%h", rd, ref_mem[0]); end
`endif
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = '0;
      written[i] = 1'b0;
    end
    test_reset();
    test_write_basic();
    test_read_basic();
    test_back_to_back();
    test_both_high();
    test_reset_mid();
    test_random();
    test_mem_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
